// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared code words, state and source encodings for the FND display arbiter
package fnd_pkg;

  // Code words understood by the segment driver
  localparam logic [31:0] FND_NULL     = 32'h00CC_0000;
  localparam logic [31:0] FND_ERROR    = 32'h00EE_0000;
  localparam logic [31:0] FND_PLUS     = 32'h0010_0000;
  localparam logic [31:0] FND_MINUS    = 32'h0020_0000;
  localparam logic [31:0] FND_MULTIPLE = 32'h0030_0000;
  localparam logic [31:0] FND_DIVID    = 32'h0040_0000;
  localparam logic [31:0] FND_MODULO   = 32'h0050_0000;
  localparam logic [31:0] FND_HAPPY    = 32'h00A0_0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHOW_MSG = 2'd1,
    ST_SHOW_ERR = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SRC_BG  = 2'd0,
    SRC_MSG = 2'd1,
    SRC_ERR = 2'd3
  } src_e;

  // True when both tick counts are representable in a w-bit counter
  function automatic bit cnt_fits(input int unsigned w, input int unsigned hold,
                                  input int unsigned blink);
    longint unsigned lim;
    lim = 64'd1 << w;
    return (longint'(hold) < lim) && (longint'(blink) < lim);
  endfunction

endpackage

// File: rtl/fnd_hold_timer.sv
// rtl/fnd_hold_timer.sv - loadable tick down-counter with expiry strobe
module fnd_hold_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             tick_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;

  // Expiry does not look at load_i, so the owner may reload on expiry without a loop
  assign expire_o = tick_i && (cnt_q == CNT_W'(1));

  // Load wins over a coincident tick; the count parks at zero
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/fnd_display_arbiter.sv
// rtl/fnd_display_arbiter.sv - shares the 6-digit FND between result, message and error (optional FND_ERR_BLINK_EN)
module fnd_display_arbiter
  import fnd_pkg::*;
#(
  parameter int HOLD_TICKS  = 1000,
  parameter int CNT_W       = 16,
  parameter int BLINK_TICKS = 250
) (
  input  logic        fnd_clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  input  logic        msg_valid,
  input  logic [31:0] msg_code,
  input  logic        err_valid,
  input  logic        clr,
  output logic [31:0] fnd_serial,
  output logic [1:0]  src,
  output logic        busy,
  output logic        msg_drop
);

  // An out-of-range configuration saturates the counters instead of wrapping
  localparam bit PARAMS_OK = (HOLD_TICKS >= 1) && (BLINK_TICKS >= 1) &&
                             cnt_fits(CNT_W, HOLD_TICKS, BLINK_TICKS);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = PARAMS_OK ? CNT_W'(HOLD_TICKS)  : {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] BLINK_LOAD = PARAMS_OK ? CNT_W'(BLINK_TICKS) : {CNT_W{1'b1}};

  state_e      state_q, state_d;
  logic [31:0] bg_q, bg_d;
  logic [31:0] cur_q, cur_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        drop_d;
  logic        hold_load, hold_tick, hold_expire;
  logic        err_entry;
  logic [31:0] err_word;
  logic [31:0] fnd_serial_q, fnd_serial_d;
  src_e        src_q, src_d;
  logic        busy_q, msg_drop_q;

  assign hold_tick = tick && (state_q == ST_SHOW_MSG);

  fnd_hold_timer #(.CNT_W(CNT_W)) u_hold (
    .clk_i      (fnd_clk),
    .rst_i      (rst),
    .load_i     (hold_load),
    .load_val_i (HOLD_LOAD),
    .tick_i     (hold_tick),
    .expire_o   (hold_expire)
  );

  // Apply this cycle's events in priority order: clr, err, hold expiry, msg, res
  always_comb begin
    state_d    = state_q;
    bg_d       = bg_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = 1'b0;
    hold_load  = 1'b0;
    err_entry  = 1'b0;

    if (clr) begin
      bg_d       = FND_NULL;
      pend_vld_d = 1'b0;
      state_d    = ST_IDLE;
    end

    if (err_valid && (state_d != ST_SHOW_ERR)) begin
      state_d   = ST_SHOW_ERR;
      err_entry = 1'b1;
    end

    // Still in SHOW_MSG here means neither clr nor err interrupted the message
    if ((state_d == ST_SHOW_MSG) && hold_expire) begin
      if (pend_vld_d) begin
        cur_d      = pend_d;
        pend_vld_d = 1'b0;
        hold_load  = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (msg_valid) begin
      if (state_d == ST_IDLE) begin
        state_d   = ST_SHOW_MSG;
        cur_d     = msg_code;
        hold_load = 1'b1;
      end else begin
        drop_d     = pend_vld_d;
        pend_d     = msg_code;
        pend_vld_d = 1'b1;
      end
    end

    if (res_valid) begin
      bg_d = res_data;
    end
  end

`ifdef FND_ERR_BLINK_EN
  logic blink_q, blink_d, blink_load, blink_tick, blink_expire;

  assign blink_tick = tick && (state_q == ST_SHOW_ERR);

  fnd_hold_timer #(.CNT_W(CNT_W)) u_blink (
    .clk_i      (fnd_clk),
    .rst_i      (rst),
    .load_i     (blink_load),
    .load_val_i (BLINK_LOAD),
    .tick_i     (blink_tick),
    .expire_o   (blink_expire)
  );

  // Blink phase restarts on ERROR at every entry and flips each half-period
  always_comb begin
    blink_d    = blink_q;
    blink_load = 1'b0;
    if (err_entry) begin
      blink_d    = 1'b0;
      blink_load = 1'b1;
    end else if ((state_d == ST_SHOW_ERR) && blink_expire) begin
      blink_d    = ~blink_q;
      blink_load = 1'b1;
    end
  end

  // Blink phase register
  always_ff @(posedge fnd_clk) begin
    if (rst) begin
      blink_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
    end
  end

  assign err_word = blink_d ? FND_NULL : FND_ERROR;
`else
  assign err_word = FND_ERROR;
`endif

  // Output word and source follow the next state so strobes show one cycle later
  always_comb begin
    fnd_serial_d = bg_d;
    src_d        = SRC_BG;
    case (state_d)
      ST_SHOW_MSG: begin
        fnd_serial_d = cur_d;
        src_d        = SRC_MSG;
      end
      ST_SHOW_ERR: begin
        fnd_serial_d = err_word;
        src_d        = SRC_ERR;
      end
      default: ;
    endcase
  end

  // FSM state, held data and registered outputs
  always_ff @(posedge fnd_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bg_q         <= FND_NULL;
      cur_q        <= FND_NULL;
      pend_q       <= FND_NULL;
      pend_vld_q   <= 1'b0;
      fnd_serial_q <= FND_NULL;
      src_q        <= SRC_BG;
      busy_q       <= 1'b0;
      msg_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bg_q         <= bg_d;
      cur_q        <= cur_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      fnd_serial_q <= fnd_serial_d;
      src_q        <= src_d;
      busy_q       <= (state_d != ST_IDLE);
      msg_drop_q   <= drop_d;
    end
  end

  assign fnd_serial = fnd_serial_q;
  assign src        = src_q;
  assign busy       = busy_q;
  assign msg_drop   = msg_drop_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// tb/tb_fnd_display_arbiter.sv - directed self-checking bench for fnd_display_arbiter
module tb_fnd_display_arbiter;
  import fnd_pkg::*;

  logic        fnd_clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        res_valid = 1'b0;
  logic [31:0] res_data = '0;
  logic        msg_valid = 1'b0;
  logic [31:0] msg_code = '0;
  logic        err_valid = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] fnd_serial;
  logic [1:0]  src;
  logic        busy;
  logic        msg_drop;

  int checks = 0;
  int errors = 0;

  always #5 fnd_clk = ~fnd_clk;

  fnd_display_arbiter #(
    .HOLD_TICKS  (3),
    .CNT_W       (16),
    .BLINK_TICKS (2)
  ) dut (
    .fnd_clk    (fnd_clk),
    .rst        (rst),
    .tick       (tick),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .msg_valid  (msg_valid),
    .msg_code   (msg_code),
    .err_valid  (err_valid),
    .clr        (clr),
    .fnd_serial (fnd_serial),
    .src        (src),
    .busy       (busy),
    .msg_drop   (msg_drop)
  );

  // Let one edge consume the driven inputs, settle, then drop the strobes
  task automatic cycle();
    @(posedge fnd_clk);
    #1;
    tick      = 1'b0;
    res_valid = 1'b0;
    msg_valid = 1'b0;
    err_valid = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] f, input logic [1:0] s,
                         input logic b);
    chk({tag, ".fnd"}, fnd_serial, f);
    chk({tag, ".src"}, {30'd0, src}, {30'd0, s});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
  endtask

  initial begin
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk_out("reset", FND_NULL, 2'd0, 1'b0);
    chk("reset.drop", {31'd0, msg_drop}, 32'd0);

    // 1: result becomes the background one cycle after its strobe
    res_valid = 1'b1; res_data = 32'd1234; cycle();
    chk_out("t1.res", 32'd1234, 2'd0, 1'b0);

    // 2: message held for exactly three ticks
    msg_valid = 1'b1; msg_code = FND_PLUS; cycle();
    chk_out("t2.load", FND_PLUS, 2'd1, 1'b1);
    tick = 1'b1; cycle();
    chk_out("t2.tick1", FND_PLUS, 2'd1, 1'b1);
    cycle();
    chk_out("t2.gap", FND_PLUS, 2'd1, 1'b1);
    tick = 1'b1; cycle();
    chk_out("t2.tick2", FND_PLUS, 2'd1, 1'b1);
    tick = 1'b1; cycle();
    chk_out("t2.tick3", 32'd1234, 2'd0, 1'b0);

    // 3: tick on the load cycle is ignored; pending overwrite drops MINUS
    msg_valid = 1'b1; msg_code = FND_PLUS; tick = 1'b1; cycle();
    chk_out("t3.load_tick", FND_PLUS, 2'd1, 1'b1);
    msg_valid = 1'b1; msg_code = FND_MINUS; cycle();
    chk("t3.first_pend.drop", {31'd0, msg_drop}, 32'd0);
    msg_valid = 1'b1; msg_code = FND_MULTIPLE; cycle();
    chk("t3.overwrite.drop", {31'd0, msg_drop}, 32'd1);
    cycle();
    chk("t3.drop_single", {31'd0, msg_drop}, 32'd0);
    tick = 1'b1; cycle();
    chk("t3.tick1", fnd_serial, FND_PLUS);
    tick = 1'b1; cycle();
    chk("t3.tick2", fnd_serial, FND_PLUS);
    tick = 1'b1; cycle();
    chk_out("t3.swap", FND_MULTIPLE, 2'd1, 1'b1);

    // 4: background update is silent until the message expires
    res_valid = 1'b1; res_data = 32'hFFFF_FFFB; cycle();
    chk_out("t4.silent", FND_MULTIPLE, 2'd1, 1'b1);
    tick = 1'b1; cycle();
    chk("t4.tick1", fnd_serial, FND_MULTIPLE);
    tick = 1'b1; cycle();
    chk("t4.tick2", fnd_serial, FND_MULTIPLE);
    tick = 1'b1; cycle();
    chk_out("t4.expire", 32'hFFFF_FFFB, 2'd0, 1'b0);

    // 5: error pre-empts a message with a pending entry; clr discards pending
    msg_valid = 1'b1; msg_code = FND_DIVID; cycle();
    chk("t5.divid", fnd_serial, FND_DIVID);
    msg_valid = 1'b1; msg_code = FND_MODULO; cycle();
    err_valid = 1'b1; cycle();
    chk_out("t5.err", FND_ERROR, 2'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; cycle();
      chk("t5.err_hold", fnd_serial, FND_ERROR);
    end
    err_valid = 1'b1; cycle();
    chk_out("t5.err_again", FND_ERROR, 2'd3, 1'b1);
    msg_valid = 1'b1; msg_code = FND_HAPPY; cycle();
    chk("t5.err_pend.drop", {31'd0, msg_drop}, 32'd1);
    clr = 1'b1; cycle();
    chk_out("t5.clr", FND_NULL, 2'd0, 1'b0);
    msg_valid = 1'b1; msg_code = FND_DIVID; cycle();
    chk("t5.after_clr", fnd_serial, FND_DIVID);
    for (int i = 0; i < 3; i++) begin
      tick = 1'b1; cycle();
    end
    chk_out("t5.pend_discarded", FND_NULL, 2'd0, 1'b0);

    // 6: clr with err in one cycle, then reset during a message
    res_valid = 1'b1; res_data = 32'd77; cycle();
    chk("t6.bg77", fnd_serial, 32'd77);
    clr = 1'b1; err_valid = 1'b1; cycle();
    chk_out("t6.clr_err", FND_ERROR, 2'd3, 1'b1);
    clr = 1'b1; cycle();
    chk_out("t6.bg_null", FND_NULL, 2'd0, 1'b0);
    res_valid = 1'b1; res_data = 32'd55; cycle();
    msg_valid = 1'b1; msg_code = FND_HAPPY; cycle();
    chk_out("t6.happy", FND_HAPPY, 2'd1, 1'b1);
    rst = 1'b1; cycle();
    chk_out("t6.rst", FND_NULL, 2'd0, 1'b0);
    chk("t6.rst.drop", {31'd0, msg_drop}, 32'd0);
    rst = 1'b0; cycle();
    chk_out("t6.post_rst", FND_NULL, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_display_arbiter.md
Name: fnd_display_arbiter

Overview:
- Shares the single 6-digit FND between three requesters: calculator result, operator/status message and error.
- Drives the 32-bit fnd_serial code word consumed by the segment driver.
- A result is the persistent background. Messages are shown for a minimum hold time, then the display returns to the background. An error pre-empts everything and stays until cleared.
- Sits between the calculator core / key FSM and the segment driver.

Parameters:
- HOLD_TICKS, 1000, number of tick pulses a message stays on the display; must be >= 1.
- CNT_W, 16, width of the hold/blink counter; must satisfy 2^CNT_W > max(HOLD_TICKS, BLINK_TICKS).
- BLINK_TICKS, 250, tick pulses per blink half-period; used only with FND_ERR_BLINK_EN.

Ports:
- fnd_clk  in  1  block clock; one clock only.
- rst  in  1  reset, synchronous, active-high.
- tick  in  1  single-cycle time-base strobe (1 ms nominal).
- res_valid  in  1  single-cycle strobe: new result on res_data.
- res_data  in  32  signed two's-complement result value.
- msg_valid  in  1  single-cycle strobe: new message on msg_code.
- msg_code  in  32  message code word (PLUS 0x0010_0000, MINUS 0x0020_0000, MULTIPLE 0x0030_0000, DIVID 0x0040_0000, MODULO 0x0050_0000, HAPPY 0x00A0_0000).
- err_valid  in  1  single-cycle strobe: error event.
- clr  in  1  single-cycle strobe: clear error and display.
- fnd_serial  out  32  code word to the segment driver.
- src  out  2  current display source: 0 = background, 1 = message, 3 = error.
- busy  out  1  high while in SHOW_MSG or SHOW_ERR.
- msg_drop  out  1  single-cycle pulse when a pending message is overwritten.

Behaviour:
- Reset (rst = 1 at a fnd_clk edge): state IDLE, bg = NULL (0x00CC_0000), pending empty, counter 0, fnd_serial = 0x00CC_0000, src = 0, busy = 0, msg_drop = 0. Reset aborts any state immediately.
- Registered outputs: fnd_serial, src and busy reflect the state and data from the previous edge, so latency is 1 cycle from strobe to output.
- Per-cycle event order: clr, then err_valid, then msg_valid, then res_valid. All events in the same cycle are applied in that order.
- clr: bg <= NULL, pending cleared, state -> IDLE.
- res_valid (any state): bg <= res_data.
  - In IDLE, fnd_serial shows the new bg next cycle.
  - Otherwise bg is updated silently and shown on return to IDLE.
- State machine:
  - IDLE
    - fnd_serial = bg.
    - err_valid -> SHOW_ERR.
    - msg_valid -> SHOW_MSG: cur <= msg_code, counter <= HOLD_TICKS.
  - SHOW_MSG
    - fnd_serial = cur; counter decrements on each tick.
    - tick with counter == 1:
      - if pending is full: cur <= pending, pending emptied, counter reloaded to HOLD_TICKS;
      - else: -> IDLE.
    - msg_valid: written to pending. If pending is already full it is overwritten and msg_drop pulses.
    - err_valid -> SHOW_ERR. The current message is discarded, not resumed; pending is kept.
  - SHOW_ERR
    - fnd_serial = ERROR (0x00EE_0000); no timeout.
    - msg_valid writes to pending, with the same drop rule as SHOW_MSG.
    - err_valid again: no effect.
    - clr: -> IDLE; pending and bg are cleared per the clr rule.
- tick in the same cycle as a counter load: the tick is ignored, and the counter holds the loaded value.
- tick is never counted in IDLE or SHOW_ERR, except for blink (see Optional Feature).
- res_data values are passed through unchecked; reserved codes are out of the 6-digit range by construction.

Optional Feature:
- Macro: FND_ERR_BLINK_EN.
- Defined: in SHOW_ERR, fnd_serial alternates ERROR / NULL every BLINK_TICKS ticks, starting with ERROR on entry. The blink phase resets on every entry to SHOW_ERR.
- Undefined: ERROR is shown steadily, and BLINK_TICKS is unused.

Decomposition:
- Shared package fnd_pkg holds:
  - code-word constants (NULL, ERROR, PLUS, MINUS, MULTIPLE, DIVID, MODULO, HAPPY);
  - state encoding (IDLE, SHOW_MSG, SHOW_ERR);
  - src encoding.
- One sub-module, fnd_hold_timer: a loadable down-counter.
  - Inputs: load, load_val, tick.
  - Output: expire, asserted on a tick with count == 1.
  - Reused for the hold counter and the blink counter.

Test Plan:
1. Reset, then res_valid with res_data = 1234 -> fnd_serial = 1234 one cycle later; src = 0, busy = 0.
2. msg_valid with 0x0010_0000 (HOLD_TICKS = 3), then 3 ticks -> PLUS shown for exactly 3 ticks, then 1234 returns; busy falls on the cycle after the 3rd tick.
3. In SHOW_MSG, msg_valid 0x0020_0000 then 0x0030_0000 -> msg_drop pulses once; after hold, MULTIPLE is shown for a full HOLD_TICKS; MINUS is never shown.
4. res_valid (-5) during SHOW_MSG -> display unchanged until expiry, then 0xFFFF_FFFB.
5. err_valid during SHOW_MSG with a pending message -> 0x00EE_0000 next cycle, held indefinitely; clr -> fnd_serial = 0x00CC_0000, pending discarded.
6. clr and err_valid in the same cycle -> SHOW_ERR with bg = NULL. rst mid-SHOW_MSG -> NULL next cycle, src = 0.
